round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter.sv | 147 ++++++++++++++
 tb/tb_round_robin_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a per-grant hold limit
// (MAX_HOLD) and a one-cycle timeout pulse when a grant is revoked by that limit.
module round_robin_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_req,
    input  logic [N-1:0]         i_done,
    output logic [N-1:0]         o_grant,
    output logic                 o_grant_valid,
    output logic [$clog2(N)-1:0] o_grant_id,
    output logic                 o_timeout
);

    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [IDW-1:0] last_ptr_r, last_ptr_s;
    logic [IDW-1:0] grant_id_r, grant_id_s;
    logic [IDW-1:0] winner_s;
    logic [7:0]     hold_cnt_r, hold_cnt_s;
    logic [N-1:0]   grant_r, grant_s;
    logic [N-1:0]   after_ptr_s, masked_req_s;
    logic           valid_r, valid_s;
    logic           timeout_r, timeout_s;
    logic           any_req_s, any_masked_s;
    logic           release_s, expire_s;

    // Lowest set bit of a request vector; scanning downwards leaves the lowest hit.
    function automatic logic [IDW-1:0] lowest_index(input logic [N-1:0] vec);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Requesters strictly after the last winner take priority over the wrapped ones.
    generate
        for (genvar k = 0; k < N; k++) begin : g_mask
            assign after_ptr_s[k]  = (k > int'(last_ptr_r));
            assign masked_req_s[k] = i_req[k] & after_ptr_s[k];
        end
    endgenerate

    // Winner selection and owner release/expiry conditions.
    always_comb begin
        any_req_s    = |i_req;
        any_masked_s = |masked_req_s;
        if (any_masked_s) begin
            winner_s = lowest_index(masked_req_s);
        end else begin
            winner_s = lowest_index(i_req);
        end
        release_s = i_done[grant_id_r] | ~i_req[grant_id_r];
        expire_s  = (hold_cnt_r == 8'(MAX_HOLD - 1));
    end

    // Next-state and next-output logic; RELEASE is the single bubble cycle and
    // arbitrates on its exit edge exactly as IDLE would.
    always_comb begin
        state_s    = state_r;
        last_ptr_s = last_ptr_r;
        hold_cnt_s = hold_cnt_r;
        grant_s    = grant_r;
        grant_id_s = grant_id_r;
        valid_s    = valid_r;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                if (any_req_s) begin
                    state_s    = ST_GRANT;
                    last_ptr_s = winner_s;
                    hold_cnt_s = 8'd0;
                    grant_s    = {{(N-1){1'b0}}, 1'b1} << winner_s;
                    grant_id_s = winner_s;
                    valid_s    = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                    hold_cnt_s = 8'd0;
                    grant_s    = '0;
                    grant_id_s = '0;
                    valid_s    = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s || expire_s) begin
                    state_s    = ST_RELEASE;
                    hold_cnt_s = 8'd0;
                    grant_s    = '0;
                    grant_id_s = '0;
                    valid_s    = 1'b0;
                    timeout_s  = ~release_s;
                end else begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = 8'd0;
                grant_s    = '0;
                grant_id_s = '0;
                valid_s    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset gives requester 0 first priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            last_ptr_r <= IDW'(N - 1);
            hold_cnt_r <= 8'd0;
            grant_r    <= '0;
            grant_id_r <= '0;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_ptr_r <= last_ptr_s;
            hold_cnt_r <= hold_cnt_s;
            grant_r    <= grant_s;
            grant_id_r <= grant_id_s;
            valid_r    <= valid_s;
            timeout_r  <= timeout_s;
        end
    end

    assign o_grant       = grant_r;
    assign o_grant_valid = valid_r;
    assign o_grant_id    = grant_id_r;
    assign o_timeout     = timeout_r;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for round_robin_arbiter (N=4, MAX_HOLD=8).
module tb_round_robin_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int checks;
    int failures;

    round_robin_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_done        (done),
        .o_grant       (grant),
        .o_grant_valid (grant_valid),
        .o_grant_id    (grant_id),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic t);
        check_eq({tag, ".grant"},   32'(grant),       32'(g));
        check_eq({tag, ".id"},      32'(grant_id),    32'(id));
        check_eq({tag, ".valid"},   32'(grant_valid), 32'(v));
        check_eq({tag, ".timeout"}, 32'(timeout),     32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        logic [1:0] seq [5];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        done     = 4'b0000;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;

        tick();
        tick();
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // first arbitration on the first edge after reset release
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        check_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // rotation 0,1,2,3,0 with done in each owner's second cycle
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << seq[n];
            check_out($sformatf("rr%0d.c1", n), oh, seq[n], 1'b1, 1'b0);
            tick();
            check_out($sformatf("rr%0d.c2", n), oh, seq[n], 1'b1, 1'b0);
            done = oh;
            tick();
            done = 4'b0000;
            check_out($sformatf("rr%0d.bubble", n), 4'b0000, 2'd0, 1'b0, 1'b0);
            if (n == 4) begin
                req = 4'b0000;
            end
            tick();
        end
        check_out("idle_after_rr", 4'b0000, 2'd0, 1'b0, 1'b0);

        // MAX_HOLD expiry on a lone requester
        req = 4'b0100;
        tick();
        for (int c = 0; c < 8; c++) begin
            check_out($sformatf("hold.c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
            tick();
        end
        check_out("hold.timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check_out("hold.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // non-owner done bits ignored
        done = 4'b1011;
        tick();
        done = 4'b0000;
        check_out("foreign_done", 4'b0100, 2'd2, 1'b1, 1'b0);

        // release in the 8th cycle wins over timeout
        repeat (6) tick();
        check_out("done8.c8", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 4'b0100;
        tick();
        done = 4'b0000;
        check_out("done8.drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("done8.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // owner drops request; wrap from ptr 2 to requester 1
        req = 4'b0010;
        tick();
        check_out("reqdrop.bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("wrap_to_1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // asynchronous reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("post_reset", 4'b0010, 2'd1, 1'b1, 1'b0);

        // hand over to 3, then wrap past N-1 to 0
        req = 4'b1000;
        tick();
        check_out("to3.bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("to3.grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0011;
        tick();
        check_out("wrap0.bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("wrap0.grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // no requests: stay idle with zero outputs
        req = 4'b0000;
        tick();
        tick();
        check_out("idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
